// File: rtl/mdp3_message_parser.sv
// MDP3 incremental-refresh record parser: pulls five 64-bit words from a show-behind FIFO,
// validates the trailer byte and presents the decoded book-update fields with a one-cycle strobe.
module mdp3_message_parser #(
  parameter int         WORDS_PER_MSG = 5,
  parameter logic [7:0] TRAILER_BYTE  = 8'hC9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] MESSAGE,
  input  logic        not_empty,
  output logic        parser_ready,
  output logic        message_ready,
  output logic [1:0]  ACTION,
  output logic [1:0]  ENTRY_TYPE,
  output logic [31:0] SECURITY_ID,
  output logic [63:0] PRICE,
  output logic [15:0] QUANTITY,
  output logic [7:0]  NUM_ORDERS
);

  localparam int              CW   = $clog2(WORDS_PER_MSG + 1);
  localparam logic [CW-1:0]   LAST = CW'(WORDS_PER_MSG);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, EMIT} state_t;

  state_t        state;
  logic [CW-1:0] req_count;
  logic [CW-1:0] rx_count;
  logic          rd_pending;
  logic [63:0]   words [WORDS_PER_MSG];

  // The read request has to follow not_empty in the same cycle, so it stays combinational.
  assign parser_ready = (state == COLLECT) && not_empty && (req_count < LAST);

  always_ff @(posedge clk) begin
    if (rd_pending) begin
      words[rx_count] <= MESSAGE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      req_count     <= '0;
      rx_count      <= '0;
      rd_pending    <= 1'b0;
      message_ready <= 1'b0;
      ACTION        <= '0;
      ENTRY_TYPE    <= '0;
      SECURITY_ID   <= '0;
      PRICE         <= '0;
      QUANTITY      <= '0;
      NUM_ORDERS    <= '0;
    end else begin
      message_ready <= 1'b0;
      rd_pending    <= parser_ready;
      if (parser_ready) begin
        req_count <= req_count + 1'b1;
      end
      if (rd_pending) begin
        rx_count <= rx_count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (not_empty) begin
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (rd_pending && (rx_count == LAST - 1'b1)) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          req_count <= '0;
          rx_count  <= '0;
          // Multi-byte fields arrive little-endian; byte 0 of each word sits in bits 63:56.
          if (words[4][47:40] == TRAILER_BYTE) begin
            ACTION        <= words[1][25:24];
            ENTRY_TYPE    <= words[1][17:16];
            SECURITY_ID   <= {words[2][55:48], words[2][63:56], words[1][7:0], words[1][15:8]};
            PRICE         <= {32'd0, words[2][23:16], words[2][31:24], words[2][39:32], words[2][47:40]};
            QUANTITY      <= {words[2][7:0], words[2][15:8]};
            NUM_ORDERS    <= words[4][63:56];
            message_ready <= 1'b1;
            state         <= EMIT;
          end else begin
            state <= IDLE;
          end
        end
        EMIT: begin
          state <= not_empty ? COLLECT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{words[0], words[1][63:26], words[1][23:18], words[3],
                         words[4][55:48], words[4][39:0]};

endmodule

// File: tb/tb_mdp3_message_parser.sv
// Directed bench for mdp3_message_parser: a small show-behind FIFO model feeds hand-built
// records and every decoded field is compared against hand-computed values.
module tb_mdp3_message_parser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] MESSAGE = '0;
  logic        not_empty;
  logic        parser_ready;
  logic        message_ready;
  logic [1:0]  ACTION;
  logic [1:0]  ENTRY_TYPE;
  logic [31:0] SECURITY_ID;
  logic [63:0] PRICE;
  logic [15:0] QUANTITY;
  logic [7:0]  NUM_ORDERS;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [63:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rdreq_count = 0;
  int strobe_count = 0;
  int bad_rdreq = 0;

  mdp3_message_parser dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .MESSAGE       (MESSAGE),
    .not_empty     (not_empty),
    .parser_ready  (parser_ready),
    .message_ready (message_ready),
    .ACTION        (ACTION),
    .ENTRY_TYPE    (ENTRY_TYPE),
    .SECURITY_ID   (SECURITY_ID),
    .PRICE         (PRICE),
    .QUANTITY      (QUANTITY),
    .NUM_ORDERS    (NUM_ORDERS)
  );

  always #5 clk = ~clk;

  assign not_empty = (wr_ptr != rd_ptr);

  // Show-behind FIFO: data for a request appears on MESSAGE after the requesting edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= wr_ptr;
    end else if (parser_ready && not_empty) begin
      MESSAGE <= mem[rd_ptr & 255];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (parser_ready) rdreq_count <= rdreq_count + 1;
      if (message_ready) strobe_count <= strobe_count + 1;
      if (parser_ready && !not_empty) bad_rdreq <= bad_rdreq + 1;
    end
  end

  task automatic pushWord(input logic [63:0] w);
    mem[wr_ptr & 255] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic applyStimulus(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2,
                               input logic [63:0] w3, input logic [63:0] w4);
    pushWord(w0);
    pushWord(w1);
    pushWord(w2);
    pushWord(w3);
    pushWord(w4);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRecord(input string tag, input logic [1:0] a, input logic [1:0] et,
                             input logic [31:0] sid, input logic [63:0] price,
                             input logic [15:0] qty, input logic [7:0] nord);
    checkOutput({tag, ".ACTION"}, 64'(ACTION), 64'(a));
    checkOutput({tag, ".ENTRY_TYPE"}, 64'(ENTRY_TYPE), 64'(et));
    checkOutput({tag, ".SECURITY_ID"}, 64'(SECURITY_ID), 64'(sid));
    checkOutput({tag, ".PRICE"}, PRICE, price);
    checkOutput({tag, ".QUANTITY"}, 64'(QUANTITY), 64'(qty));
    checkOutput({tag, ".NUM_ORDERS"}, 64'(NUM_ORDERS), 64'(nord));
  endtask

  task automatic waitStrobe(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (message_ready) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput({tag, ".strobe_seen"}, 64'(got), 64'd1);
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int rd0;
    int st0;

    // Reset state.
    waitCycles(3);
    checkOutput("reset.parser_ready", 64'(parser_ready), 64'd0);
    checkOutput("reset.message_ready", 64'(message_ready), 64'd0);
    checkRecord("reset", 2'd0, 2'd0, 32'd0, 64'd0, 16'd0, 8'd0);
    reset_n = 1'b1;
    waitCycles(2);

    // Record 1: new bid, padding bits of the last word are garbage.
    rd0 = rdreq_count;
    st0 = strobe_count;
    applyStimulus(64'hC0C21C02_3D010000, 64'h68038001_00007B00, 64'h00000C00_00000900,
                  64'h00000000_000000AE, 64'h0001C900_00ABCDEF);
    waitStrobe("rec1");
    checkRecord("rec1", 2'd0, 2'd0, 32'd123, 64'd12, 16'd9, 8'd0);
    @(negedge clk);
    checkOutput("rec1.strobe_one_cycle", 64'(message_ready), 64'd0);
    waitCycles(4);
    checkOutput("rec1.rdreq_count", 64'(rdreq_count - rd0), 64'd5);
    checkOutput("rec1.strobe_count", 64'(strobe_count - st0), 64'd1);

    // Record 2: change.
    applyStimulus(64'hC0C21C02_3D010000, 64'h68038001_01007B00, 64'h00000C00_00000500,
                  64'h00000000_00000005, 64'h0002C900_00000000);
    waitStrobe("rec2");
    checkRecord("rec2", 2'd1, 2'd0, 32'd123, 64'd12, 16'd5, 8'd0);
    waitCycles(3);

    // Record 3: ask side with four orders.
    applyStimulus(64'hC0C21C02_3D010000, 64'h68038001_00017B00, 64'h00000C00_00000300,
                  64'h00000000_00000000, 64'h0403C900_00000000);
    waitStrobe("rec3");
    checkRecord("rec3", 2'd0, 2'd1, 32'd123, 64'd12, 16'd3, 8'd4);
    waitCycles(3);

    // Corrupted trailer: consumed but dropped, outputs keep record 3.
    rd0 = rdreq_count;
    st0 = strobe_count;
    applyStimulus(64'hC0C21C02_3D010000, 64'h11111111_02037856, 64'h3412EFBE_ADDECDAB,
                  64'h99880000_00000000, 64'hFF000000_00000000);
    waitCycles(25);
    checkOutput("bad.strobe_count", 64'(strobe_count - st0), 64'd0);
    checkOutput("bad.rdreq_count", 64'(rdreq_count - rd0), 64'd5);
    checkRecord("bad_hold", 2'd0, 2'd1, 32'd123, 64'd12, 16'd3, 8'd4);

    // Good record after the drop, exercising full-width little-endian fields and out-of-range codes.
    applyStimulus(64'hC0C21C02_3D010000, 64'h11111111_02037856, 64'h3412EFBE_ADDECDAB,
                  64'h99880000_00000000, 64'hFF00C900_00000000);
    waitStrobe("rec5");
    checkRecord("rec5", 2'd2, 2'd3, 32'h12345678, 64'h00000000_DEADBEEF, 16'hABCD, 8'hFF);
    waitCycles(3);

    // FIFO runs dry after word 2.
    rd0 = rdreq_count;
    pushWord(64'hC0C21C02_3D010000);
    pushWord(64'h68038001_01007B00);
    waitCycles(10);
    checkOutput("stall.rdreq_count", 64'(rdreq_count - rd0), 64'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall.parser_ready_low", 64'(parser_ready), 64'd0);
    end
    pushWord(64'h00000C00_00000500);
    pushWord(64'h00000000_00000005);
    pushWord(64'h0002C900_00000000);
    waitStrobe("stall");
    checkRecord("stall", 2'd1, 2'd0, 32'd123, 64'd12, 16'd5, 8'd0);
    waitCycles(3);

    // Reset after word 3 of a record.
    pushWord(64'hC0C21C02_3D010000);
    pushWord(64'h68038001_00017B00);
    pushWord(64'h00000C00_00000300);
    waitCycles(10);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset.message_ready", 64'(message_ready), 64'd0);
    checkRecord("midreset", 2'd0, 2'd0, 32'd0, 64'd0, 16'd0, 8'd0);
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(2);
    st0 = strobe_count;
    applyStimulus(64'hC0C21C02_3D010000, 64'h68038001_00007B00, 64'h00000C00_00000900,
                  64'h00000000_000000AE, 64'h0001C900_00ABCDEF);
    waitStrobe("after_reset");
    checkRecord("after_reset", 2'd0, 2'd0, 32'd123, 64'd12, 16'd9, 8'd0);
    waitCycles(10);
    checkOutput("after_reset.strobe_count", 64'(strobe_count - st0), 64'd1);
    checkOutput("rdreq_while_empty", 64'(bad_rdreq), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
